// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multicycle control state machine for the lab CPU datapath. Decodes the
// instruction-register opcode and sequences the datapath register enables
// and mux selects. It waits on mem_ready during memory accesses and counts
// retired instructions.
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   defined   : an unrecognised opcode enters TRAP (held until reset, illegal_op = 1)
//   undefined : an unrecognised opcode retires as a NOP (DECODE -> FETCH, not counted)
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   op_code [OP_W]           opcode from the instruction register
//   mem_ready                memory completes the current access this cycle
//   MemRead/MemWrite         memory strobes
//   PC_Reg_Write(_BEQ)       PC write enables (unconditional / zero-qualified)
//   *_Reg_Write, Register_File_Write   datapath load enables
//   *_Select, ALU_Ctrl       datapath mux selects and ALU operation
//   state_dbg [4]            current state code
//   illegal_op               trap indicator
//   instr_count [CNT_W]      retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int unsigned     OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
  parameter logic [OP_W-1:0] OP_LW    = 6'h23,
  parameter logic [OP_W-1:0] OP_SW    = 6'h2B,
  parameter logic [OP_W-1:0] OP_BEQ   = 6'h04,
  parameter logic [OP_W-1:0] OP_J     = 6'h02,
  parameter logic [OP_W-1:0] OP_ADDI  = 6'h08,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  op_code,
  input  logic             mem_ready,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             PC_Reg_Write,
  output logic             PC_Reg_Write_BEQ,
  output logic             Instruction_Reg_Write,
  output logic             Memory_Data_Reg_Write,
  output logic             A_Reg_Write,
  output logic             B_Reg_Write,
  output logic             ALU_Op_Reg_Write,
  output logic             Register_File_Write,
  output logic             IorD_Mux_Select,
  output logic             Write_Data_Mux_Select,
  output logic             Reg_Dst_Select,
  output logic             ALU_A_Mux_Select,
  output logic [1:0]       ALU_B_Mux_Select,
  output logic [1:0]       ALU_Ctrl,
  output logic [1:0]       PC_Source_Mux_Select,
  output logic [3:0]       state_dbg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  // Registered Moore control word; fetch/mdr_load are later qualified by mem_ready
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       pc_write_beq;
    logic       fetch;
    logic       mdr_load;
    logic       a_we;
    logic       b_we;
    logic       aluout_we;
    logic       rf_we;
    logic       iord;
    logic       wd_sel;
    logic       reg_dst;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  state_t     state;
  state_t     next_state_c;
  ctrl_t      ctrl_q;
  logic       retire_c;

  // Control word for a given state; anything not set stays 0
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.fetch    = 1'b1;
        c.alu_b    = 2'b01;
      end
      S_DECODE: begin
        c.a_we      = 1'b1;
        c.b_we      = 1'b1;
        c.aluout_we = 1'b1;
        c.alu_b     = 2'b11;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        c.alu_a     = 1'b1;
        c.alu_b     = 2'b10;
        c.aluout_we = 1'b1;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        c.mdr_load = 1'b1;
      end
      S_MEM_WB: begin
        c.rf_we  = 1'b1;
        c.wd_sel = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_a     = 1'b1;
        c.alu_ctrl  = 2'b10;
        c.aluout_we = 1'b1;
      end
      S_R_WB: begin
        c.rf_we   = 1'b1;
        c.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        c.alu_a        = 1'b1;
        c.alu_ctrl     = 2'b01;
        c.pc_src       = 2'b01;
        c.pc_write_beq = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      S_I_WB: begin
        c.rf_we = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        c.illegal = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; decode priority LW > SW > RTYPE > BEQ > J > ADDI
  always_comb begin
    next_state_c = state;
    case (state)
      S_IDLE:      next_state_c = S_FETCH;
      S_FETCH:     if (mem_ready) next_state_c = S_DECODE;
      S_DECODE: begin
        if ((op_code == OP_LW) || (op_code == OP_SW)) next_state_c = S_MEM_ADDR;
        else if (op_code == OP_RTYPE)                 next_state_c = S_R_EXEC;
        else if (op_code == OP_BEQ)                   next_state_c = S_BRANCH;
        else if (op_code == OP_J)                     next_state_c = S_JUMP;
        else if (op_code == OP_ADDI)                  next_state_c = S_I_EXEC;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          next_state_c = S_TRAP;
`else
          next_state_c = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR:  next_state_c = (op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) next_state_c = S_MEM_WB;
      S_MEM_WB:    next_state_c = S_FETCH;
      S_MEM_WRITE: if (mem_ready) next_state_c = S_FETCH;
      S_R_EXEC:    next_state_c = S_R_WB;
      S_R_WB:      next_state_c = S_FETCH;
      S_BRANCH:    next_state_c = S_FETCH;
      S_JUMP:      next_state_c = S_FETCH;
      S_I_EXEC:    next_state_c = S_I_WB;
      S_I_WB:      next_state_c = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:      next_state_c = S_TRAP;
`endif
      default:     next_state_c = S_IDLE;
    endcase
  end

  // An instruction retires only when a completing state hands back to FETCH
  always_comb begin
    retire_c = 1'b0;
    if (next_state_c == S_FETCH) begin
      case (state)
        S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: retire_c = 1'b1;
        default: retire_c = 1'b0;
      endcase
    end
  end

  // State, control word and retire counter; control word tracks the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ctrl_q      <= '0;
      instr_count <= '0;
    end else begin
      state  <= next_state_c;
      ctrl_q <= decode_state(next_state_c);
      if (retire_c) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // mem_ready gates IR/PC load in FETCH and MDR load in MEM_READ so each happens once
  assign Instruction_Reg_Write = ctrl_q.fetch & mem_ready;
  assign PC_Reg_Write          = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
  assign Memory_Data_Reg_Write = ctrl_q.mdr_load & mem_ready;

  assign MemRead               = ctrl_q.mem_read;
  assign MemWrite              = ctrl_q.mem_write;
  assign PC_Reg_Write_BEQ      = ctrl_q.pc_write_beq;
  assign A_Reg_Write           = ctrl_q.a_we;
  assign B_Reg_Write           = ctrl_q.b_we;
  assign ALU_Op_Reg_Write      = ctrl_q.aluout_we;
  assign Register_File_Write   = ctrl_q.rf_we;
  assign IorD_Mux_Select       = ctrl_q.iord;
  assign Write_Data_Mux_Select = ctrl_q.wd_sel;
  assign Reg_Dst_Select        = ctrl_q.reg_dst;
  assign ALU_A_Mux_Select      = ctrl_q.alu_a;
  assign ALU_B_Mux_Select      = ctrl_q.alu_b;
  assign ALU_Ctrl              = ctrl_q.alu_ctrl;
  assign PC_Source_Mux_Select  = ctrl_q.pc_src;
  assign state_dbg             = 4'(state);
  // Without the trap feature the illegal bit is never set, so this is constant 0
  assign illegal_op            = ctrl_q.illegal;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised multicycle control state machine for the lab CPU datapath.
- Decodes the opcode held in the instruction register and sequences the PC, IR, MDR, A/B, ALUOut and register-file write enables, plus the datapath mux selects.
- Successor to the fixed-opcode controller. Adds configurable opcode encodings, BEQ/J/ADDI support, a memory-ready wait handshake, a retired-instruction counter and optional illegal-opcode trapping.

Parameters:
- OP_W, 6, opcode width.
- OP_RTYPE, 6'h00, R-type opcode.
- OP_LW, 6'h23, load-word opcode.
- OP_SW, 6'h2B, store-word opcode.
- OP_BEQ, 6'h04, branch-equal opcode.
- OP_J, 6'h02, jump opcode.
- OP_ADDI, 6'h08, add-immediate opcode.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  Rising-edge clock.
- reset_n  in  1  Asynchronous, active-low reset.
- op_code  in  OP_W  Opcode field from the instruction register.
- mem_ready  in  1  Memory completes the current read or write this cycle.
- MemRead  out  1  Memory read strobe.
- MemWrite  out  1  Memory write strobe.
- PC_Reg_Write  out  1  Unconditional PC write enable.
- PC_Reg_Write_BEQ  out  1  PC write enable, qualified by ALU zero in the datapath.
- Instruction_Reg_Write  out  1  IR load enable.
- Memory_Data_Reg_Write  out  1  MDR load enable.
- A_Reg_Write  out  1  A register load enable.
- B_Reg_Write  out  1  B register load enable.
- ALU_Op_Reg_Write  out  1  ALUOut load enable.
- Register_File_Write  out  1  Register-file write enable.
- IorD_Mux_Select  out  1  Memory address source: 0 = PC, 1 = ALUOut.
- Write_Data_Mux_Select  out  1  Register-file write data: 0 = ALUOut, 1 = MDR.
- Reg_Dst_Select  out  1  Destination register: 0 = rt, 1 = rd.
- ALU_A_Mux_Select  out  1  ALU A input: 0 = PC, 1 = A.
- ALU_B_Mux_Select  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALU_Ctrl  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field.
- PC_Source_Mux_Select  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_dbg  out  4  Current state code.
- illegal_op  out  1  Trap indicator.
- instr_count  out  CNT_W  Retired-instruction count.

Behaviour:
- Outputs are a Moore decode of the registered state. Any output not listed for a state is 0.
- Reset: while reset_n = 0, state = IDLE, all outputs = 0 and instr_count = 0. IDLE moves to FETCH unconditionally on the next edge after release.
- Asserting reset_n low in any state aborts the instruction immediately; there is no partial write-back.
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12, TRAP 13.
- FETCH:
  - Outputs: MemRead = 1, IorD = 0, ALU_A = 0, ALU_B = 01, ALU_Ctrl = 00, PC_Source = 00.
  - Instruction_Reg_Write and PC_Reg_Write equal mem_ready.
  - Holds in FETCH while mem_ready = 0. Goes to DECODE when mem_ready = 1, so the PC advances exactly once per fetch.
- DECODE:
  - Outputs: A, B and ALUOut writes = 1; ALU_A = 0, ALU_B = 11, ALU_Ctrl = 00.
  - Next state: LW or SW → MEM_ADDR; RTYPE → R_EXEC; BEQ → BRANCH; J → JUMP; ADDI → I_EXEC; any other opcode → see Optional Feature.
  - Opcode matching uses the parameter values. If two parameters are equal, priority is LW > SW > RTYPE > BEQ > J > ADDI.
- MEM_ADDR: ALU_A = 1, ALU_B = 10, ALU_Ctrl = 00, ALUOut write = 1. Next state is MEM_READ for LW, MEM_WRITE for SW. The opcode is resampled here and the IR is stable.
- MEM_READ: MemRead = 1, IorD = 1, Memory_Data_Reg_Write = mem_ready. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: Register_File_Write = 1, Write_Data = 1, Reg_Dst = 0. Next state FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1. Holds until mem_ready, then goes to FETCH. The strobe stays asserted throughout the wait.
- R_EXEC: ALU_A = 1, ALU_B = 00, ALU_Ctrl = 10, ALUOut write = 1. Next state R_WB.
- R_WB: Register_File_Write = 1, Write_Data = 0, Reg_Dst = 1. Next state FETCH.
- BRANCH: ALU_A = 1, ALU_B = 00, ALU_Ctrl = 01, PC_Source = 01, PC_Reg_Write_BEQ = 1. Next state FETCH.
- JUMP: PC_Source = 10, PC_Reg_Write = 1. Next state FETCH.
- I_EXEC: same outputs as MEM_ADDR. Next state I_WB.
- I_WB: Register_File_Write = 1, Write_Data = 0, Reg_Dst = 0. Next state FETCH.
- Cycle counts, assuming zero wait:
  - LW: 5 cycles.
  - SW, R-type, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each mem_ready = 0 cycle adds one cycle.
- instr_count:
  - Increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or I_WB.
  - Does not increment on IDLE→FETCH or on an illegal-opcode return to FETCH.
  - Wraps from 2^CNT_W−1 to 0.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unrecognised opcode in DECODE goes to TRAP. TRAP drives all strobes and enables to 0 and illegal_op = 1, and stays there until reset_n is asserted.
- Undefined: an unrecognised opcode returns DECODE → FETCH as a NOP (PC already advanced). The TRAP state is unreachable and illegal_op is tied to 0.

Test Plan:
- Release reset with mem_ready = 1 and op_code = 6'h00 → state_dbg sequence 0,1,2,7,8,1. Register_File_Write = 1 with Reg_Dst = 1 in R_WB. instr_count = 1.
- LW (6'h23) with mem_ready = 0 for 3 cycles in MEM_READ → MEM_READ held 4 cycles with MemRead = 1 and IorD = 1. Memory_Data_Reg_Write pulses once. Total 8 cycles FETCH to FETCH.
- SW (6'h2B) → MemWrite = 1 for exactly 1 cycle. Register_File_Write never asserted. Return to FETCH.
- BEQ (6'h04) then J (6'h02) → BRANCH shows ALU_Ctrl = 01, PC_Source = 01, PC_Reg_Write_BEQ = 1. JUMP shows PC_Source = 10, PC_Reg_Write = 1. instr_count increments by 2.
- Opcode 6'h3F: with the macro → state 13 and illegal_op = 1, held for 20 cycles until reset. Without the macro → DECODE→FETCH and instr_count unchanged.
- reset_n asserted low mid-MEM_WRITE (asynchronous, between edges) → immediately state 0, MemWrite = 0, instr_count = 0. Next, CNT_W = 2 with 4 ADDI instructions → instr_count wraps to 0.
